logic_unit_nbits: RTL and testbench
===================================

LOGIC_UNIT_NBITS -- requirements
Module: logic_unit_nbits

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 2: bits processed per RUN cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 The block SHALL have one clock, clk, input, 1 bit: all state updates on the rising edge.
REQ-004 The block SHALL have reset rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have input start, 1 bit: request to begin an operation.
REQ-006 The block SHALL have input op, 2 bits: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 The block SHALL have inputs a and b, WIDTH bits each: the operands.
REQ-008 The block SHALL have output busy, 1 bit: high while in RUN.
REQ-009 The block SHALL have output done, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have output result, WIDTH bits: the registered operation result.
REQ-011 The block SHALL have output zero, 1 bit, present only when LOGIC_UNIT_ZERO_FLAG_EN is defined.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture a, b and op into internal registers, clear result to 0, clear the chunk index to 0, and enter RUN.
REQ-014 In RUN, each cycle SHALL write result[k*CHUNK +: CHUNK] = op(a_r, b_r) for the same slice, where k is the chunk index, and then increment k.
REQ-015 After the chunk k = WIDTH/CHUNK-1 is written, the FSM SHALL enter DONE; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-016 Latency: with start accepted at edge t, done SHALL be high in the cycle following edge t+N+1, where N = WIDTH/CHUNK (t+5 for WIDTH=8, CHUNK=2; t+2 for CHUNK=WIDTH).
REQ-017 busy SHALL be 1 only in RUN, and done SHALL be 1 only in DONE; the two SHALL never be high together.
REQ-018 start SHALL be ignored in RUN and in DONE; a new start SHALL be accepted only from IDLE, including the cycle immediately after DONE.
REQ-019 Changes on a, b or op after acceptance SHALL NOT affect the operation in progress.
REQ-020 result SHALL hold its final value from DONE until the next start is accepted.
REQ-021 Unprocessed result slices SHALL read 0 during RUN.

Reset
REQ-022 While rst_n=0, the block SHALL force state to IDLE, the chunk index to 0, captured operands to 0, and busy, done, result (and zero, when present) to 0, immediately and independent of clk.
REQ-023 A reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-024 After rst_n deasserts, the first rising edge SHALL already accept start.

Configuration
REQ-025 With LOGIC_UNIT_ZERO_FLAG_EN defined, output zero SHALL be registered as (final result == 0), updated in the same edge that enters DONE, held until the next accepted start, and cleared to 0 on accept.
REQ-026 Without LOGIC_UNIT_ZERO_FLAG_EN, the zero port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 The bench SHALL run with WIDTH=8, CHUNK=2: OR, a=8'hFF, b=8'h00, start at t -> result=8'hFF, done high exactly one cycle at t+5, busy high for 4 cycles.
REQ-028 The bench SHALL run OR, a=8'hFF, b=8'hA9 -> result=8'hFF; then AND with the same operands -> result=8'hA9; then OR, a=8'h9D, b=8'h9F -> result=8'h9F.
REQ-029 The bench SHALL run XOR, a=8'h9D, b=8'h9F -> result=8'h02; then NOR, a=8'h00, b=8'h00 -> result=8'hFF; and check for a partial slice pattern during RUN (for example, after 2 RUN cycles of the NOR, result=8'h0F).
REQ-030 The bench SHALL pulse start with a=8'h00 during RUN of AND 8'hF0 & 8'hFF -> the second request is ignored, result=8'hF0, and exactly one done pulse occurs.
REQ-031 The bench SHALL drive rst_n=0 in the 2nd RUN cycle -> busy, done and result go to 0 without a clock edge, and no done pulse follows; a subsequent OR 8'h01 | 8'h80 -> result=8'h81.
REQ-032 With LOGIC_UNIT_ZERO_FLAG_EN defined, the bench SHALL run AND 8'hF0 & 8'h0F -> result=8'h00, zero=1 at done; then OR 8'h00 | 8'h01 -> zero=0.

Source files
------------

// File: rtl/logic_unit_nbits_if.sv
// Operand/result bundle for logic_unit_nbits.
// The zero flag exists only when LOGIC_UNIT_ZERO_FLAG_EN is defined.
interface logic_unit_nbits_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic             zero;
`endif

  modport master (
    output start, op, a, b,
    input  busy, done, result
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    , input zero
`endif
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    , output zero
`endif
  );
endinterface

// File: rtl/logic_unit_nbits.sv
// Chunk-serial bitwise logic unit: AND/OR/XOR/NOR computed CHUNK bits per cycle.
// Optional registered zero flag is built when LOGIC_UNIT_ZERO_FLAG_EN is defined.
module logic_unit_nbits #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input logic              clk,
  input logic              rst_n,
  logic_unit_nbits_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((WIDTH % CHUNK) != 0 || CHUNK == 0) begin : g_bad_cfg
      $error("logic_unit_nbits: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] op_full;
  logic [WIDTH-1:0] next_result;
  logic             last_chunk;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic             zero_q;
`endif

  // Full-width operation on the captured operands; RUN merges one slice per cycle.
  always_comb begin
    op_full = '0;
    unique case (op_r)
      2'b00:   op_full = a_r & b_r;
      2'b01:   op_full = a_r | b_r;
      2'b10:   op_full = a_r ^ b_r;
      default: op_full = ~(a_r | b_r);
    endcase
  end

  always_comb begin
    next_result = result_q;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (k == KW'(i)) next_result[i*CHUNK +: CHUNK] = op_full[i*CHUNK +: CHUNK];
    end
  end

  assign last_chunk = (k == KW'(NCHUNK - 1));

  // busy/done are registered from the state, so each trails its state by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      busy_q <= (state == RUN);
      done_q <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            op_r     <= bus.op;
            a_r      <= bus.a;
            b_r      <= bus.b;
            result_q <= '0;
            k        <= '0;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
            state    <= RUN;
          end
        end
        RUN: begin
          result_q <= next_result;
          if (last_chunk) begin
            k     <= '0;
            state <= DONE;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
            zero_q <= (next_result == '0);
`endif
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  assign bus.zero   = zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_nbits.sv
// Self-checking bench for logic_unit_nbits (WIDTH=8, CHUNK=2): vector table,
// random operations against a reference model, and hand-written corner sequences.
module tb_logic_unit_nbits;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CHUNK = 2;
  localparam int unsigned NCH   = WIDTH / CHUNK;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic_unit_nbits_if #(.WIDTH(WIDTH)) bus ();

  logic_unit_nbits #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; leaves at a negedge.
  task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp);
    int done_at;
    int busy_n;
    int overlap;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 2'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
    done_at = 0; busy_n = 0; overlap = 0;
    for (int i = 1; i <= 20 && done_at == 0; i++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_n++;
      if (bus.busy && bus.done) overlap++;
      if (bus.done) done_at = i;
    end
    check({name, " done_latency"}, 32'(done_at), 32'(NCH + 1));
    check({name, " busy_cycles"}, 32'(busy_n), 32'(NCH));
    check({name, " busy_done_overlap"}, 32'(overlap), 32'd0);
    check({name, " result"}, 32'(bus.result), 32'(exp));
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    check({name, " zero"}, 32'(bus.zero), 32'(exp == 8'h00));
`endif
    @(posedge clk); #1;
    check({name, " done_single"}, 32'(bus.done), 32'd0);
    check({name, " result_hold"}, 32'(bus.result), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    tbl[0] = '{"or_ff_00",  2'b01, 8'hFF, 8'h00, 8'hFF};
    tbl[1] = '{"or_ff_a9",  2'b01, 8'hFF, 8'hA9, 8'hFF};
    tbl[2] = '{"and_ff_a9", 2'b00, 8'hFF, 8'hA9, 8'hA9};
    tbl[3] = '{"or_9d_9f",  2'b01, 8'h9D, 8'h9F, 8'h9F};
    tbl[4] = '{"xor_9d_9f", 2'b10, 8'h9D, 8'h9F, 8'h02};
    tbl[5] = '{"nor_00_00", 2'b11, 8'h00, 8'h00, 8'hFF};
    tbl[6] = '{"and_f0_0f", 2'b00, 8'hF0, 8'h0F, 8'h00};
    tbl[7] = '{"or_00_01",  2'b01, 8'h00, 8'h01, 8'h01};
    tbl[8] = '{"and_f0_ff", 2'b00, 8'hF0, 8'hFF, 8'hF0};

    rst_n = 1'b0; bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    #3;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First op issued on the very first edge after reset release.
    for (int i = 0; i < 9; i++) run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

    // Partial slices during RUN of NOR 00,00.
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 8'h00; bus.b = 8'h00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("partial_accept", 32'(bus.result), 32'd0);
    @(posedge clk); #1;
    check("partial_1", 32'(bus.result), 32'h03);
    @(posedge clk); #1;
    check("partial_2", 32'(bus.result), 32'h0F);
    repeat (4) @(posedge clk);
    #1 check("partial_final", 32'(bus.result), 32'hFF);
    @(negedge clk);

    // start during RUN and DONE must be ignored.
    begin
      int dones;
      dones = 0;
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 8'hF0; bus.b = 8'hFF;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 1; i <= 12; i++) begin
        @(posedge clk); #1;
        if (bus.done) dones++;
        bus.start = (i == 2 || i == 4);
        if (i == 2) bus.a = 8'h00;
      end
      check("ignore_start_dones", 32'(dones), 32'd1);
      check("ignore_start_result", 32'(bus.result), 32'hF0);
      check("ignore_start_idle", 32'(bus.busy), 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset in the second RUN cycle aborts the operation.
    begin
      int dones;
      dones = 0;
      bus.start = 1'b1; bus.op = 2'b10; bus.a = 8'hFF; bus.b = 8'h0F;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      check("pre_reset_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_busy", 32'(bus.busy), 32'd0);
      check("async_done", 32'(bus.done), 32'd0);
      check("async_result", 32'(bus.result), 32'd0);
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        if (bus.done) dones++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (bus.done || bus.busy) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      @(negedge clk);
      run_op("post_reset_or", 2'b01, 8'h01, 8'h80, 8'h81);
    end

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = 8'($urandom);
      run_op($sformatf("rand%0d", i), op, a, b, model(op, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
